sec_a2b_serial: RTL and testbench



---
 rtl/sec_a2b_pkg.sv | 26 ++
 rtl/sec_and_bit_n.sv | 29 ++
 rtl/sec_a2b_serial.sv | 147 ++++++++++++++
 tb/tb_sec_a2b_serial.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sec_a2b_pkg.sv
// Shared constants and helpers for the serial masked A2B converter.
package sec_a2b_pkg;

    // FSM state encoding
    typedef logic [1:0] a2b_state_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Randomness bits consumed per bit step (two SecAnd gadgets)
    function automatic int unsigned rnd_width(input int unsigned n);
        return n * (n - 1);
    endfunction

    // Offset of unordered share pair (i,j) in lexicographic order (0,1),(0,2),...
    function automatic int unsigned rnd_pair_idx(input int unsigned i,
                                                 input int unsigned j,
                                                 input int unsigned n);
        int unsigned lo;
        int unsigned hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return (lo * (2 * n - lo - 1)) / 2 + (hi - lo - 1);
    endfunction

endpackage

// File: rtl/sec_and_bit_n.sv
// Combinational N-share 1-bit DOM-indep AND; r_ij = r_ji shared per pair.
module sec_and_bit_n
    import sec_a2b_pkg::*;
#(
    parameter int unsigned N_SHARES = 8
) (
    input  logic [N_SHARES-1:0]                  b,
    input  logic [N_SHARES-1:0]                  x,
    input  logic [N_SHARES*(N_SHARES-1)/2-1:0]   r,
    output logic [N_SHARES-1:0]                  z
);

    localparam int unsigned P = rnd_width(N_SHARES) / 2;

    // Inner-domain term plus each cross-domain term refreshed by its pair mask
    always_comb begin
        z = '0;
        for (int unsigned i = 0; i < N_SHARES; i++) begin
            z[i] = b[i] & x[i];
            for (int unsigned j = 0; j < N_SHARES; j++) begin
                if (j != i) begin
                    z[i] = z[i] ^ (b[i] & x[j])
                         ^ (|(r & (P'(1) << rnd_pair_idx(i, j, N_SHARES))));
                end
            end
        end
    end

endmodule

// File: rtl/sec_a2b_serial.sv
// Bit-serial masked arithmetic-to-Boolean converter: folds one arithmetic
// share per pass into a Boolean accumulator through a masked ripple adder.
module sec_a2b_serial
    import sec_a2b_pkg::*;
#(
    parameter int unsigned K_WIDTH  = 32,
    parameter int unsigned N_SHARES = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                i_dvld,
    output logic                                o_ready,
    input  logic                                i_rvld,
    input  logic [N_SHARES*(N_SHARES-1)-1:0]    i_n,
    input  logic [N_SHARES*K_WIDTH-1:0]         i_a,
    output logic [N_SHARES*K_WIDTH-1:0]         o_z,
    output logic                                o_dvld
);

    localparam int unsigned RW    = rnd_width(N_SHARES);
    localparam int unsigned P     = RW / 2;
    localparam int unsigned IDX_W = $clog2(N_SHARES);
    localparam int unsigned BIT_W = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

    typedef logic [N_SHARES-1:0][K_WIDTH-1:0] share_vec_t;

    a2b_state_t          state_q, state_d;
    share_vec_t          a_q, a_d;
    share_vec_t          b_q, b_d;
    logic [N_SHARES-1:0] c_q, c_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BIT_W-1:0]    pos_q, pos_d;
    logic                ready_q, ready_d;
    share_vec_t          z_d;
    logic                dvld_d;

    logic [N_SHARES-1:0] bj, xv, bx, g, h;

    // Current bit column of the accumulator and the (unmasked) operand bit
    always_comb begin
        bj = '0;
        xv = '0;
        for (int unsigned k = 0; k < N_SHARES; k++) begin
            bj[k] = b_q[k][pos_q];
        end
        xv[0] = a_q[idx_q][pos_q];
        bx    = bj ^ xv;
    end

    // Generate term B&x
    sec_and_bit_n #(.N_SHARES(N_SHARES)) u_and_g (
        .b (bj),
        .x (xv),
        .r (i_n[0 +: P]),
        .z (g)
    );

    // Propagate term c&(B^x), using the pre-update accumulator bit
    sec_and_bit_n #(.N_SHARES(N_SHARES)) u_and_h (
        .b (c_q),
        .x (bx),
        .r (i_n[P +: P]),
        .z (h)
    );

    // Next-state and datapath update; accept overrides IDLE/DONE transitions
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        z_d     = o_z;
        dvld_d  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (i_rvld) begin
                    for (int unsigned k = 0; k < N_SHARES; k++) begin
                        b_d[k][pos_q] = bj[k] ^ xv[k] ^ c_q[k];
                    end
                    if (pos_q == BIT_W'(K_WIDTH - 1)) begin
                        c_d   = '0;
                        pos_d = '0;
                        if (idx_q == IDX_W'(N_SHARES - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        c_d   = g ^ h;
                        pos_d = pos_q + BIT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                z_d     = b_q;
                dvld_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (i_dvld && ready_q) begin
            a_d     = i_a;
            b_d     = '0;
            b_d[0]  = i_a[K_WIDTH-1:0];
            c_d     = '0;
            idx_d   = IDX_W'(1);
            pos_d   = '0;
            state_d = ST_RUN;
        end

        ready_d = (state_d != ST_RUN);
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            ready_q <= 1'b1;
            o_z     <= '0;
            o_dvld  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            ready_q <= ready_d;
            o_z     <= z_d;
            o_dvld  <= dvld_d;
        end
    end

    assign o_ready = ready_q;

endmodule

// File: tb/tb_sec_a2b_serial.sv
// Directed bench for sec_a2b_serial: default 8x32 build and a 2x8 build.
module tb_sec_a2b_serial;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-share, 32-bit instance
    logic         b_dvld, b_rvld, b_ready, b_ovld;
    logic [55:0]  b_n;
    logic [255:0] b_a, b_z;

    // 2-share, 8-bit instance
    logic         s_dvld, s_rvld, s_ready, s_ovld;
    logic [1:0]   s_n;
    logic [15:0]  s_a, s_z;

    int n_total = 0;
    int n_pass  = 0;

    sec_a2b_serial #(.K_WIDTH(32), .N_SHARES(8)) u_dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .i_dvld  (b_dvld),
        .o_ready (b_ready),
        .i_rvld  (b_rvld),
        .i_n     (b_n),
        .i_a     (b_a),
        .o_z     (b_z),
        .o_dvld  (b_ovld)
    );

    sec_a2b_serial #(.K_WIDTH(8), .N_SHARES(2)) u_small (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .i_dvld  (s_dvld),
        .o_ready (s_ready),
        .i_rvld  (s_rvld),
        .i_n     (s_n),
        .i_a     (s_a),
        .o_z     (s_z),
        .o_dvld  (s_ovld)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] fold_big(input logic [255:0] z);
        logic [31:0] acc;
        acc = '0;
        for (int k = 0; k < 8; k++) acc = acc ^ z[k*32 +: 32];
        return acc;
    endfunction

    // Random arithmetic sharing of target (sum of the 8 words mod 2^32)
    function automatic logic [255:0] make_shares(input logic [31:0] target);
        logic [255:0] v;
        logic [31:0]  w;
        logic [31:0]  sum;
        sum = '0;
        for (int k = 0; k < 7; k++) begin
            w = $urandom;
            v[k*32 +: 32] = w;
            sum = sum + w;
        end
        v[255:224] = target - sum;
        return v;
    endfunction

    // Present shares for one cycle; returns #1 after the accept edge
    task automatic start_big(input logic [255:0] a);
        b_a    = a;
        b_dvld = 1'b1;
        @(posedge clk); #1;
        b_dvld = 1'b0;
    endtask

    // Wait for o_dvld; lat = edges after accept, last_step = edge of the 224th rvld-high step.
    // With b2b set, a new job (a_next) is presented during the DONE cycle.
    task automatic wait_big(input bit zero_n, input bit stall, input bit b2b,
                            input logic [255:0] a_next, output int lat, output int last_step);
        int steps;
        lat = 0;
        last_step = -1;
        steps = 0;
        while (lat < 2000) begin
            b_rvld = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            b_n    = zero_n ? 56'd0 : 56'({$urandom, $urandom});
            if (b2b && lat == 224) begin
                b_a    = a_next;
                b_dvld = 1'b1;
            end
            @(posedge clk);
            if (b_rvld && steps < 224) begin
                steps++;
                if (steps == 224) last_step = lat + 1;
            end
            #1;
            lat++;
            if (b2b && lat == 225) b_dvld = 1'b0;
            if (b_ovld) break;
        end
        b_rvld = 1'b1;
    endtask

    initial begin
        int lat;
        int ls;
        int hits;
        logic [255:0] a;
        logic [255:0] a2;

        rst_n  = 1'b0;
        b_dvld = 1'b0; b_rvld = 1'b1; b_n = '0; b_a = '0;
        s_dvld = 1'b0; s_rvld = 1'b1; s_n = '0; s_a = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",   256'(b_ready), 256'(1));
        check("rst_dvld",    256'(b_ovld),  256'(0));
        check("rst_z",       b_z,           256'(0));
        check("rst_s_ready", 256'(s_ready), 256'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic conversion, random masks, no stall
        a = make_shares(32'hDEADBEEF);
        start_big(a);
        check("busy_ready", 256'(b_ready), 256'(0));
        wait_big(1'b0, 1'b0, 1'b0, '0, lat, ls);
        check("basic_lat", 256'(lat), 256'(225));
        check("basic_val", 256'(fold_big(b_z)), 256'(32'hDEADBEEF));
        @(posedge clk); #1;
        check("pulse_width", 256'(b_ovld), 256'(0));
        check("z_hold", 256'(fold_big(b_z)), 256'(32'hDEADBEEF));

        // Wrap-around: 8 * 0xFFFFFFFF mod 2^32
        start_big({8{32'hFFFFFFFF}});
        wait_big(1'b0, 1'b0, 1'b0, '0, lat, ls);
        check("wrap_val", 256'(fold_big(b_z)), 256'(32'hFFFFFFF8));
        start_big({8{32'hFFFFFFFF}});
        wait_big(1'b1, 1'b0, 1'b0, '0, lat, ls);
        check("wrap_zero_n", 256'(fold_big(b_z)), 256'(32'hFFFFFFF8));

        // Randomness stall at ~50% duty
        a = make_shares(32'hCAFEF00D);
        start_big(a);
        wait_big(1'b0, 1'b1, 1'b0, '0, lat, ls);
        check("stall_val", 256'(fold_big(b_z)), 256'(32'hCAFEF00D));
        check("stall_lat", 256'(lat), 256'(ls + 1));

        // Back-to-back: second job accepted in the DONE cycle
        a  = make_shares(32'h0BADC0DE);
        a2 = make_shares(32'h12345678);
        start_big(a);
        wait_big(1'b0, 1'b0, 1'b1, a2, lat, ls);
        check("b2b_lat1", 256'(lat), 256'(225));
        check("b2b_val1", 256'(fold_big(b_z)), 256'(32'h0BADC0DE));
        check("b2b_busy", 256'(b_ready), 256'(0));
        wait_big(1'b0, 1'b0, 1'b0, '0, lat, ls);
        check("b2b_lat2", 256'(lat), 256'(225));
        check("b2b_val2", 256'(fold_big(b_z)), 256'(32'h12345678));

        // Small build: 0x80 + 0x80 wraps to 0; busy-time i_dvld is ignored
        s_a = {8'h80, 8'h80};
        s_dvld = 1'b1;
        @(posedge clk); #1;
        s_dvld = 1'b0;
        lat = 0;
        while (lat < 100) begin
            s_n    = 2'($urandom);
            s_dvld = (lat == 3 || lat == 4);
            if (lat == 3) s_a = {8'h11, 8'h22};
            @(posedge clk); #1;
            lat++;
            if (s_ovld) break;
        end
        s_dvld = 1'b0;
        check("small_lat", 256'(lat), 256'(9));
        check("small_val", 256'(s_z[7:0] ^ s_z[15:8]), 256'(8'h00));

        // Small build: 0x7F + 0x03 with zero masks
        s_a = {8'h03, 8'h7F};
        s_n = 2'b00;
        s_dvld = 1'b1;
        @(posedge clk); #1;
        s_dvld = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (s_ovld) break;
        end
        check("small2_lat", 256'(lat), 256'(9));
        check("small2_val", 256'(s_z[7:0] ^ s_z[15:8]), 256'(8'h82));

        // Asynchronous reset 100 steps into a job
        a = make_shares(32'h55AA1234);
        start_big(a);
        for (int c = 0; c < 100; c++) begin
            b_n = 56'({$urandom, $urandom});
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_z",     b_z,           256'(0));
        check("abort_ready", 256'(b_ready), 256'(1));
        check("abort_dvld",  256'(b_ovld),  256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hits = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (b_ovld) hits++;
        end
        check("abort_no_dvld", 256'(hits), 256'(0));
        a = make_shares(32'h600DF00D);
        start_big(a);
        wait_big(1'b0, 1'b0, 1'b0, '0, lat, ls);
        check("post_rst_lat", 256'(lat), 256'(225));
        check("post_rst_val", 256'(fold_big(b_z)), 256'(32'h600DF00D));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
